// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed multiply/divide unit that owns the
// HI/LO pair. One shift-add (mult) or restoring-divide (div) iteration per
// cycle on operand magnitudes, followed by a sign fix-up cycle that writes
// HI/LO. Stalls the pipeline on any mult/div/mfhi/mflo while busy.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [3:0]       alu_contr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  localparam logic [3:0]       OP_MULT  = 4'b1000;
  localparam logic [3:0]       OP_DIV   = 4'b1001;
  localparam logic [3:0]       OP_MFHI  = 4'b0011;
  localparam logic [3:0]       OP_MFLO  = 4'b0100;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + WIDTH'(1);
  endfunction

  // Two's-complement negation of a 2*WIDTH-bit value.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    neg_2w = ~v + (2*WIDTH)'(1);
  endfunction

  // Magnitude of a signed WIDTH-bit value (the most negative value maps to 2^(WIDTH-1)).
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    abs_w = v[WIDTH-1] ? neg_w(v) : v;
  endfunction

  state_t               state_r, state_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   acc_r, acc_step_s;
  logic [WIDTH-1:0]     opnd_r;
  logic                 is_div_r, neg_q_r, neg_r_r;
  logic [WIDTH-1:0]     hi_r, lo_r, hi_fix_s, lo_fix_s;
  logic                 busy_r, done_r;
  logic                 is_muldiv_s, is_read_s, start_s, div0_s;
  logic [WIDTH:0]       mul_sum_s, rem_sh_s, div_diff_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;

  assign is_muldiv_s = (alu_contr == OP_MULT) || (alu_contr == OP_DIV);
  assign is_read_s   = (alu_contr == OP_MFHI) || (alu_contr == OP_MFLO);
  assign start_s     = req && is_muldiv_s && (state_r == IDLE) && !flush;
  assign div0_s      = (alu_contr == OP_DIV) && (op_b == {WIDTH{1'b0}});
  assign stall       = busy_r && req && (is_muldiv_s || is_read_s);
  assign busy        = busy_r;
  assign done        = done_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

  // Next-state logic: flush always returns to IDLE; divide by zero skips CALC.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nx_s = div0_s ? FIX : CALC;
        else         state_nx_s = IDLE;
      end
      CALC: begin
        if (flush)                 state_nx_s = IDLE;
        else if (cnt_r == CNT_LAST) state_nx_s = FIX;
        else                       state_nx_s = CALC;
      end
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // One multiply or divide iteration on the shared 2*WIDTH accumulator.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    rem_sh_s   = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff_s = rem_sh_s - {1'b0, opnd_r};
    acc_step_s = acc_r;
    if (is_div_r) begin
      if (!div_diff_s[WIDTH]) acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      else                    acc_step_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end else begin
      if (acc_r[0]) acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      else          acc_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
    end
  end

  // Sign fix-up of the unsigned result into HI/LO values.
  always_comb begin
    prod_s = neg_q_r ? neg_2w(acc_r) : acc_r;
    quo_s  = neg_q_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    rem_s  = neg_r_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
    if (is_div_r) begin
      hi_fix_s = rem_s;
      lo_fix_s = quo_s;
    end else begin
      hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_s[WIDTH-1:0];
    end
  end

  // Register reads: only a non-stalled mfhi/mflo drives data, otherwise zero.
  always_comb begin
    rd_data = {WIDTH{1'b0}};
    if (req && !stall) begin
      case (alu_contr)
        OP_MFHI: rd_data = hi_r;
        OP_MFLO: rd_data = lo_r;
        default: rd_data = {WIDTH{1'b0}};
      endcase
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Datapath: operand latch on start, iterate in CALC, write HI/LO in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != IDLE);
      done_r <= (state_r == FIX) && !flush;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= (alu_contr == OP_DIV);
            if (div0_s) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              acc_r   <= {op_a, {WIDTH{1'b1}}};
              opnd_r  <= {WIDTH{1'b0}};
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end else if (alu_contr == OP_DIV) begin
              acc_r   <= {{WIDTH{1'b0}}, abs_w(op_a)};
              opnd_r  <= abs_w(op_b);
              neg_q_r <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              neg_r_r <= op_a[WIDTH-1];
            end else begin
              acc_r   <= {{WIDTH{1'b0}}, abs_w(op_b)};
              opnd_r  <= abs_w(op_a);
              neg_q_r <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              neg_r_r <= 1'b0;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            acc_r <= acc_step_s;
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        FIX: begin
          if (!flush) begin
            hi_r <= hi_fix_s;
            lo_r <= lo_fix_s;
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of mult/div cases with
// hand-computed HI/LO and latency, then sequences for interlock, flush,
// back-to-back issue and asynchronous reset.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b0011;
  localparam logic [3:0] OP_MFLO = 4'b0100;
  localparam logic [3:0] OP_NOP  = 4'b0000;

  logic         clk = 1'b0;
  logic         rst_n, req, flush;
  logic [3:0]   alu_contr;
  logic [W-1:0] op_a, op_b;
  logic         stall, busy, done;
  logic [W-1:0] rd_data, hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .alu_contr(alu_contr),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .busy(busy),
    .done(done), .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an op for one edge, then drop the request.
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    req = 1'b1; alu_contr = op; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    req = 1'b0; alu_contr = OP_NOP; op_a = '0; op_b = '0;
  endtask

  // Count negedges after the start edge until done; bounded.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat, bcnt, scnt;
    logic seen_done;
    logic [W-1:0] keep_hi, keep_lo;

    vecs[0]  = '{OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 34};
    vecs[1]  = '{OP_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 34};
    vecs[2]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
    vecs[3]  = '{OP_DIV,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 2};
    vecs[4]  = '{OP_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 34};
    vecs[5]  = '{OP_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 34};
    vecs[6]  = '{OP_MULT, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 34};
    vecs[7]  = '{OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 34};
    vecs[8]  = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
    vecs[9]  = '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 34};
    vecs[10] = '{OP_DIV,  32'd0,        32'd5,        32'h00000000, 32'h00000000, 34};
    vecs[11] = '{OP_MULT, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 34};
    vecs[12] = '{OP_DIV,  32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 2};

    rst_n = 1'b0; req = 1'b0; flush = 1'b0; alu_contr = OP_NOP; op_a = '0; op_b = '0;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_rd", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_lat - 1);
      check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      req = 1'b1; alu_contr = OP_MFHI;
      #1;
      check($sformatf("v%0d_mfhi", i), rd_data, vecs[i].exp_hi);
      check($sformatf("v%0d_mfhi_stall", i), stall, 0);
      alu_contr = OP_MFLO;
      #1;
      check($sformatf("v%0d_mflo", i), rd_data, vecs[i].exp_lo);
      req = 1'b0; alu_contr = OP_NOP;
    end

    // Read interlock: mflo right behind a mult (lo currently 0xFFFFFFFF).
    @(negedge clk);
    req = 1'b1; alu_contr = OP_MULT; op_a = 32'h00010000; op_b = 32'h00010000;
    @(posedge clk);
    #1;
    alu_contr = OP_MFLO; op_a = '0; op_b = '0;
    @(negedge clk);
    check("ilk_stall_first", stall, 1);
    check("ilk_rd_while_stalled", rd_data, 0);
    scnt = 1; lat = 0;
    for (int i = 2; i <= 60; i++) begin
      @(negedge clk);
      if (!stall) begin
        lat = i;
        break;
      end
      scnt++;
    end
    check("ilk_stall_cycles", scnt, 33);
    check("ilk_release_done", done, 1);
    check("ilk_rd_lo", rd_data, 32'h00000000);
    check("ilk_hi", hi, 32'h00000001);
    req = 1'b0; alu_contr = OP_NOP;

    // Flush at counter == 10: no done, HI/LO unchanged.
    keep_hi = 32'h00000001; keep_lo = 32'h00000000;
    start_op(OP_MULT, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("flush_no_done", seen_done, 0);
    check("flush_hi", hi, keep_hi);
    check("flush_lo", lo, keep_lo);

    // Flush in IDLE suppresses start.
    @(negedge clk);
    req = 1'b1; alu_contr = OP_MULT; op_a = 32'd3; op_b = 32'd4; flush = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; alu_contr = OP_NOP; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", busy, 0);

    // Non-muldiv code has no effect.
    @(negedge clk);
    req = 1'b1; alu_contr = 4'b0010; op_a = 32'd5; op_b = 32'd6;
    #1;
    check("nop_rd", rd_data, 0);
    check("nop_stall", stall, 0);
    @(posedge clk);
    #1;
    req = 1'b0; alu_contr = OP_NOP;
    @(negedge clk);
    check("nop_busy", busy, 0);
    check("nop_hi", hi, keep_hi);

    // Back-to-back: div held behind a running mult.
    @(negedge clk);
    req = 1'b1; alu_contr = OP_MULT; op_a = 32'd7; op_b = 32'hFFFFFFFD;
    @(posedge clk);
    #1;
    alu_contr = OP_DIV; op_a = 32'd100; op_b = 32'hFFFFFFF9;
    scnt = 0; lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (stall) scnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("b2b_first_lat", lat, 34);
    check("b2b_stall_cycles", scnt, 33);
    check("b2b_first_hi", hi, 32'hFFFFFFFF);
    check("b2b_first_lo", lo, 32'hFFFFFFEB);
    @(posedge clk);
    #1;
    req = 1'b0; alu_contr = OP_NOP; op_a = '0; op_b = '0;
    wait_done(lat, bcnt);
    check("b2b_second_lat", lat, 34);
    check("b2b_second_hi", hi, 32'h00000002);
    check("b2b_second_lo", lo, 32'hFFFFFFF2);

    // Asynchronous reset mid-CALC.
    start_op(OP_MULT, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(OP_MULT, 32'h7FFFFFFF, 32'd2);
    wait_done(lat, bcnt);
    check("post_rst_lat", lat, 34);
    check("post_rst_hi", hi, 32'h00000000);
    check("post_rst_lo", lo, 32'hFFFFFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle signed multiply/divide engine that owns the HI/LO register pair for the 5-stage MIPS pipeline.
- Sits in EX, beside the single-cycle ALU.
- Accepts mult/div/mfhi/mflo using the 4-bit ALU control encoding (1000 mult, 1001 div, 0011 mfhi, 0100 mflo). Drives a stall to the hazard unit while a result is pending.
- Runs 1 iteration/cycle (shift-add multiply, restoring divide), then applies sign fix-up.

Parameters:
- WIDTH, 32, operand / HI / LO width
- CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  EX-stage instruction valid for this unit
- alu_contr  in  4  operation: 1000 mult, 1001 div, 0011 mfhi, 0100 mflo; all other codes are no-op
- op_a  in  WIDTH  rs value, multiplicand or dividend
- op_b  in  WIDTH  rt value, multiplier or divisor
- flush  in  1  synchronous abort of in-flight op (branch/exception squash)
- stall  out  1  combinational: hold IF/ID/EX this cycle
- busy  out  1  registered: operation in flight
- done  out  1  registered 1-cycle pulse when HI/LO are updated
- rd_data  out  WIDTH  combinational HI (mfhi) or LO (mflo); 0 when no read
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0.
  - Reset mid-operation abandons the operation; HI/LO return to 0.
- Start condition: req=1, alu_contr in {1000,1001}, state=IDLE, flush=0.
- States:
  - IDLE -> CALC on start. Latch |op_a|, |op_b|, op type, result sign(s); counter=0.
  - CALC: one iteration per cycle. counter increments; at counter==WIDTH-1 -> FIX.
    - mult: if multiplier LSB=1, add multiplicand to the upper half of the 2*WIDTH accumulator; then shift right 1.
    - div: shift remainder:quotient left 1; trial-subtract divisor from remainder; if non-negative, keep it and set quotient LSB=1.
  - FIX -> IDLE.
    - Negate product if signs differ: hi=upper, lo=lower.
    - div: lo=quotient, negated if signs differ; hi=remainder, negated if dividend negative.
    - done=1 in the following cycle.
- Divide by zero (op_b=0 at start): goes IDLE -> FIX directly, skipping CALC. Result lo=all ones, hi=op_a. Total 2 cycles.
- Latency, start accepted at edge E0:
  - CALC occupies E1..E32; FIX writes HI/LO at E33.
  - done high during the cycle after E33; busy high from after E0 through E33.
- Overflow -2^31 / -1: lo=0x80000000, hi=0. No trap.
- stall = busy & req & (alu_contr in {1000,1001,0011,0100}). It is never asserted in IDLE, so mfhi/mflo issued the cycle after done reads the new value.
- Reads:
  - rd_data = hi for 0011, lo for 0100, when req=1 and stall=0; otherwise 0.
  - HI/LO are read-only to the pipeline; only FIX writes them.
- A start while busy is not accepted. stall holds the instruction until IDLE, then it starts normally.
- flush:
  - In CALC or FIX: -> IDLE next edge; HI/LO unchanged; done not pulsed; busy=0.
  - In IDLE: suppresses start.
  - Flush beats start in the same cycle.
- Non-muldiv codes with req=1 have no effect on state, HI/LO or outputs.

Test Plan:
- Multiply: mult op_a=7, op_b=0xFFFFFFFD (-3) -> busy for 33 cycles, done pulse, lo=0xFFFFFFEB, hi=0xFFFFFFFF.
- Divide: div op_a=100, op_b=0xFFFFFFF9 (-7) -> lo=0xFFFFFFF2 (-14), hi=2. Also check div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Read interlock: mult 0x10000 * 0x10000, then mflo on the next cycle -> stall=1 until done, then rd_data=0x00000000 and hi reads 0x00000001.
- Divide by zero: div op_a=0x1234, op_b=0 -> done two cycles after start, lo=0xFFFFFFFF, hi=0x1234.
- Flush: flush at CALC counter=10 -> IDLE next cycle, no done pulse, HI/LO keep prior values. Back-to-back start while busy -> stalled, then executes after done.
- Reset: rst_n=0 mid-CALC, asynchronously between edges -> busy, done, hi and lo go to 0 immediately. After rst_n=1, a new mult completes correctly.
